// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register busy scoreboard; x0 reads zero and is never busy.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_DEPTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_READ       = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_READ*REG_ADDR_WIDTH-1:0]  ra,
    output logic [NUM_READ*DATA_WIDTH-1:0]      rd,
    output logic [NUM_READ-1:0]                 rbusy,
    input  logic                                issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]           issue_rd,
    output logic                                issue_ready,
    input  logic                                we,
    input  logic [REG_ADDR_WIDTH-1:0]           wa,
    input  logic [DATA_WIDTH-1:0]               wd,
    output logic [REG_ADDR_WIDTH:0]             busy_count
);

    localparam logic [REG_ADDR_WIDTH:0] DEPTH = (REG_ADDR_WIDTH+1)'(REG_DEPTH);

    logic [DATA_WIDTH-1:0] regs [REG_DEPTH];
    logic [REG_DEPTH-1:0]  busy;
    logic [REG_DEPTH-1:0]  busy_next;
    logic                  wr_en;
    logic                  set_en;
    logic                  issue_busy;

    function automatic logic in_range(input logic [REG_ADDR_WIDTH-1:0] a);
        return (a != '0) && ({1'b0, a} < DEPTH);
    endfunction

    function automatic logic [REG_ADDR_WIDTH:0] popcount(input logic [REG_DEPTH-1:0] v);
        logic [REG_ADDR_WIDTH:0] c;
        c = '0;
        for (int unsigned i = 0; i < REG_DEPTH; i++) begin
            c = c + (REG_ADDR_WIDTH+1)'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        wr_en       = we && in_range(wa);
        issue_busy  = in_range(issue_rd) ? busy[issue_rd] : 1'b0;
        issue_ready = (issue_rd == '0) || !issue_busy || (we && (wa == issue_rd));
        set_en      = issue_valid && issue_ready && in_range(issue_rd);
    end

    // Set after clear so a same-edge reservation outlives the writeback release.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wa] = 1'b0;
        end
        if (set_en) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            if (in_range(ra[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH])) begin
                rd[k*DATA_WIDTH +: DATA_WIDTH] = regs[ra[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
                rbusy[k]                       = busy[ra[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (ra[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == wa)) begin
                rd[k*DATA_WIDTH +: DATA_WIDTH] = wd;
                rbusy[k]                       = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_en) begin
                regs[wa] <= wd;
            end
            busy       <= busy_next;
            busy_count <= popcount(busy_next);
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed bench for regfile_scoreboard against an array-based model.
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rbusy;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic             issue_ready;
    logic             we;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [AW:0]      busy_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_reg  [DEPTH];
    bit            m_busy [DEPTH];

    regfile_scoreboard #(
        .DATA_WIDTH(DW), .REG_DEPTH(DEPTH), .REG_ADDR_WIDTH(AW), .NUM_READ(NR)
    ) dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .we(we), .wa(wa), .wd(wd), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int a);
        if (a == 0 || a >= DEPTH) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && int'(wa) == a) return wd;
`endif
        return m_reg[a];
    endfunction

    function automatic bit m_rbusy(input int a);
        if (a == 0 || a >= DEPTH) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we && int'(wa) == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic bit m_ready();
        int r = int'(issue_rd);
        return (r == 0) || (r >= DEPTH) || !m_busy[r] || (we && wa == issue_rd);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH-1));
        return AW'($urandom_range(0, 7));
    endfunction

    // Compare all outputs with the model, then advance the model across one edge.
    task automatic cycle();
        bit rdy;
        #1;
        for (int k = 0; k < NR; k++) begin
            check("rd", 64'(rd[k*DW +: DW]), 64'(m_read(int'(ra[k*AW +: AW]))));
            check("rbusy", 64'(rbusy[k]), 64'(m_rbusy(int'(ra[k*AW +: AW]))));
        end
        rdy = m_ready();
        check("issue_ready", 64'(issue_ready), 64'(rdy));
        check("busy_count", 64'(busy_count), 64'(m_count()));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) begin
                m_reg[wa]  = wd;
                m_busy[wa] = 1'b0;
            end
            if (issue_valid && rdy && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
        #2;
    endtask

    task automatic idle();
        rst = 1'b0; issue_valid = 1'b0; issue_rd = '0; we = 1'b0; wa = '0; wd = '0; ra = '0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = 'x;
            m_busy[i] = 1'b0;
        end
        idle();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) begin
            ra = {AW'(a), AW'(a)};
            #1;
            check("rst_rd0", 64'(rd[DW-1:0]), 64'd0);
            check("rst_rd1", 64'(rd[2*DW-1:DW]), 64'd0);
            check("rst_rbusy", 64'(rbusy), 64'd0);
            cycle();
        end
        check("rst_count", 64'(busy_count), 64'd0);
        check("rst_ready", 64'(issue_ready), 64'd1);

        issue_valid = 1'b1; issue_rd = 5; cycle();
        issue_valid = 1'b0; ra = {AW'(0), AW'(5)}; #1;
        check("x5_busy", 64'(rbusy[0]), 64'd1);
        check("x5_count", 64'(busy_count), 64'd1);
        cycle();
        issue_valid = 1'b1; issue_rd = 5; #1;
        check("x5_reissue", 64'(issue_ready), 64'd0);
        cycle();
        issue_valid = 1'b0; we = 1'b1; wa = 5; wd = 32'hDEADBEEF; cycle();
        we = 1'b0; #1;
        check("x5_data", 64'(rd[DW-1:0]), 64'hDEADBEEF);
        check("x5_free", 64'(rbusy[0]), 64'd0);
        check("x5_count0", 64'(busy_count), 64'd0);
        cycle();

        issue_valid = 1'b1; issue_rd = 7; cycle();
        we = 1'b1; wa = 7; wd = 32'h0000_0777; #1;
        check("x7_ready", 64'(issue_ready), 64'd1);
        cycle();
        idle(); ra = {AW'(0), AW'(7)}; #1;
        check("x7_data", 64'(rd[DW-1:0]), 64'h777);
        check("x7_busy", 64'(rbusy[0]), 64'd1);
        check("x7_count", 64'(busy_count), 64'd1);
        cycle();
        we = 1'b1; wa = 7; wd = 32'h0000_0778; cycle();

        idle(); we = 1'b1; wa = 0; wd = 32'h1234; issue_valid = 1'b1; issue_rd = 0; #1;
        check("x0_ready", 64'(issue_ready), 64'd1);
        cycle();
        idle(); #1;
        check("x0_rd", 64'(rd[DW-1:0]), 64'd0);
        check("x0_count", 64'(busy_count), 64'd0);
        cycle();

        we = 1'b1; wa = 3; wd = 32'h1111; cycle();
        ra = {AW'(3), AW'(0)}; wd = 32'hA5A5A5A5; #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_rd1", 64'(rd[2*DW-1:DW]), 64'hA5A5A5A5);
`else
        check("bypass_rd1", 64'(rd[2*DW-1:DW]), 64'h1111);
`endif
        cycle();
        we = 1'b0; #1;
        check("after_rd1", 64'(rd[2*DW-1:DW]), 64'hA5A5A5A5);
        cycle();

        for (int r = 1; r <= 3; r++) begin
            idle(); issue_valid = 1'b1; issue_rd = AW'(r); cycle();
        end
        idle(); rst = 1'b1; we = 1'b1; wa = 2; wd = 32'h99; cycle();
        idle(); ra = {AW'(1), AW'(2)}; #1;
        check("rstw_rd", 64'(rd[DW-1:0]), 64'd0);
        check("rstw_busy", 64'(rbusy), 64'd0);
        check("rstw_count", 64'(busy_count), 64'd0);
        cycle();

        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            ra          = {rand_addr(), rand_addr()};
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = rand_addr();
            we          = ($urandom_range(0, 2) == 0);
            wa          = rand_addr();
            wd          = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-read-port integer register file with a per-register busy scoreboard for the pipelined core. It sits between decode/issue and writeback. Decode reads operands and their busy flags. Issue reserves a destination register through a valid/ready handshake. Writeback stores results and releases the reservation. Register 0 is hard-wired to zero and never becomes busy.

## Interface
- DATA_WIDTH, 32, register width in bits
- REG_DEPTH, 32, number of registers, must be ≤ 2^REG_ADDR_WIDTH
- REG_ADDR_WIDTH, 5, register address width
- NUM_READ, 2, number of independent read ports, 1..4
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- ra  input  NUM_READ*REG_ADDR_WIDTH  read addresses, port k at bits [k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
- rd  output  NUM_READ*DATA_WIDTH  read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
- rbusy  output  NUM_READ  busy flag of the register addressed by port k
- issue_valid  input  1  issue requests reservation of issue_rd
- issue_rd  input  REG_ADDR_WIDTH  destination register to reserve
- issue_ready  output  1  reservation accepted this cycle when high together with issue_valid
- we  input  1  writeback enable
- wa  input  REG_ADDR_WIDTH  writeback address
- wd  input  DATA_WIDTH  writeback data
- busy_count  output  REG_ADDR_WIDTH+1  number of registers currently busy

## Operation
- Storage: REG_DEPTH×DATA_WIDTH array plus a REG_DEPTH-bit busy vector. busy[0] is constant 0.
- Reset (rst high at a clock edge): all registers cleared to 0, all busy bits cleared, busy_count = 0. Reset overrides a same-cycle write or issue. A reservation in flight is discarded; its later writeback still stores data normally.
- Read, per port: rd = 0 and rbusy = 0 when address is 0. Otherwise rd = Reg[ra] and rbusy = busy[ra]. Addresses ≥ REG_DEPTH return 0 and not busy.
- Writeback: when we is high and wa is nonzero and below REG_DEPTH, Reg[wa] ← wd and busy[wa] ← 0 at the edge. A write to a non-busy register is legal and still stores data. Writes to register 0 are ignored.
- Issue handshake: issue_ready = (issue_rd == 0) or !busy[issue_rd] or (we and wa == issue_rd).
  - On issue_valid and issue_ready with issue_rd nonzero: busy[issue_rd] ← 1 at the edge.
  - Issue to register 0 is accepted with no state change.
  - issue_ready does not depend on issue_valid.
- Simultaneous writeback and issue to the same register: data is written and busy ends set (the new reservation wins).
- busy_count tracks the popcount of the busy vector. Per edge it changes by +1 (set only), −1 (clear only) or 0. It never exceeds REG_DEPTH−1.

## Timing
- Reads are combinational, with zero latency from ra.
- Write data and busy changes are visible on reads the cycle after the edge, unless bypass is enabled (see Configuration).
- issue_ready is combinational from issue_rd, we, wa and the busy state.
- busy_count is registered and reflects the edge's set/clear in the next cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read port whose nonzero ra equals wa while we is high returns wd combinationally, with rbusy = 0, in the same cycle.
  - If an issue is accepted to that register in the same cycle, rbusy still reads 0 during that cycle.
- REGFILE_BYPASS_EN undefined: no bypass. Reads return the stored value and busy state until the next edge.

## Test plan
- Reset, then read all registers on both ports -> rd = 0 and rbusy = 0 for every address, busy_count = 0, issue_ready = 1.
- Write sequence:
  - Issue x5, then with ra0 = 5 -> rbusy[0] = 1 and busy_count = 1.
  - Issue x5 again -> issue_ready = 0.
  - Write 0xDEADBEEF to x5, then next cycle -> rd0 = 0xDEADBEEF, rbusy[0] = 0, busy_count = 0.
- Same-cycle writeback and issue of x7 -> issue_ready = 1. Next cycle rd = written value, rbusy = 1, busy_count unchanged from its prior value of 1.
- Write 0x1234 to x0 and issue x0 -> rd for ra = 0 stays 0, busy_count stays 0, issue_ready = 1.
- Bypass, with ra1 = 3 and we = 1, wa = 3, wd = 0xA5A5A5A5 in the same cycle:
  - With REGFILE_BYPASS_EN -> rd1 = 0xA5A5A5A5 that cycle.
  - Without REGFILE_BYPASS_EN -> old value that cycle, 0xA5A5A5A5 the next cycle.
- Issue x1..x3, then assert rst together with a write to x2 -> next cycle all busy = 0, busy_count = 0, x2 reads 0.
